// File: rtl/pmem_responder_pkg.sv
// Shared types for the pmem line responder: bus/word typedefs, line offset
// width and the responder state encoding.
package pmem_responder_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] pmem_bus;

  localparam int PMEM_OFFSET_BITS = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    BUSY = 3'd1,
    RESP = 3'd2,
    DONE = 3'd3,
    INIT = 3'd4
  } pmem_resp_state;

endpackage

// File: rtl/pmem_responder_control.sv
// FSM and latency counter for pmem_responder. Optional zero-fill sweep of the
// line storage after reset when PMEM_ZERO_INIT_EN is defined.
module pmem_responder_control
  import pmem_responder_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int INDEX_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_read,
  input  logic                   i_write,
  output logic                   o_load_req,
  output logic                   o_load_rdata,
  output logic                   o_mem_write,
  output logic                   o_pmem_resp,
  output logic                   o_init_active,
  output logic [INDEX_WIDTH-1:0] o_init_index
);

  localparam logic [2:0] S_IDLE = IDLE;
  localparam logic [2:0] S_BUSY = BUSY;
  localparam logic [2:0] S_RESP = RESP;
  localparam logic [2:0] S_DONE = DONE;
`ifdef PMEM_ZERO_INIT_EN
  localparam logic [2:0] S_INIT = INIT;
  localparam logic [2:0] S_RESET = S_INIT;
  localparam logic [INDEX_WIDTH-1:0] SWEEP_LAST = '1;
`else
  localparam logic [2:0] S_RESET = S_IDLE;
`endif
  localparam logic [7:0] LOAD_COUNT = 8'(LATENCY - 1);

  logic [2:0] r_state, w_state_next;
  logic [7:0] r_count, w_count_next;
  logic       r_is_write;
  logic       w_req;
  logic       w_op_write;

  assign w_req      = i_read | i_write;
  assign o_load_req = (r_state == S_IDLE) && w_req;
  // A simultaneous read+write is a write; before acceptance the live input decides.
  assign w_op_write = (r_state == S_IDLE) ? i_write : r_is_write;

`ifdef PMEM_ZERO_INIT_EN
  logic [INDEX_WIDTH-1:0] r_sweep;
`endif

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_count_next = LOAD_COUNT;
          w_state_next = (LATENCY == 1) ? S_RESP : S_BUSY;
        end
      end
      S_BUSY: begin
        w_count_next = r_count - 8'd1;
        if (r_count == 8'd1) w_state_next = S_RESP;
      end
      S_RESP: w_state_next = S_DONE;
      S_DONE: w_state_next = S_IDLE;
`ifdef PMEM_ZERO_INIT_EN
      S_INIT: if (r_sweep == SWEEP_LAST) w_state_next = S_IDLE;
`endif
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_RESET;
      r_count    <= '0;
      r_is_write <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      if (o_load_req) r_is_write <= i_write;
    end
  end

  assign o_load_rdata = (w_state_next == S_RESP) && (r_state != S_RESP) && !w_op_write;
  assign o_pmem_resp  = (r_state == S_RESP);

`ifdef PMEM_ZERO_INIT_EN
  always_ff @(posedge clk) begin
    if (reset) r_sweep <= '0;
    else if (r_state == S_INIT) r_sweep <= r_sweep + 1'b1;
  end

  assign o_init_active = (r_state == S_INIT);
  assign o_init_index  = r_sweep;
  assign o_mem_write   = !reset && (((r_state == S_RESP) && r_is_write) || (r_state == S_INIT));
`else
  assign o_init_active = 1'b0;
  assign o_init_index  = '0;
  // Gating with reset keeps a reset on the commit edge from writing the line.
  assign o_mem_write   = !reset && (r_state == S_RESP) && r_is_write;
`endif

endmodule

// File: rtl/pmem_responder.sv
// Line-granular pmem responder: latches one request, answers with a one-cycle
// pmem_resp after LATENCY edges. Optional PMEM_ZERO_INIT_EN zero-fills storage.
module pmem_responder
  import pmem_responder_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int INDEX_WIDTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  lc3b_word pmem_address,
  input  logic     pmem_read,
  input  logic     pmem_write,
  input  pmem_bus  pmem_wdata,
  output pmem_bus  pmem_rdata,
  output logic     pmem_resp
);

  localparam int LINES  = 2 ** INDEX_WIDTH;
  localparam int IDX_LO = PMEM_OFFSET_BITS;
  localparam int IDX_HI = INDEX_WIDTH + PMEM_OFFSET_BITS - 1;

  pmem_bus                r_mem [LINES];
  pmem_bus                r_wdata;
  pmem_bus                r_rdata;
  logic [INDEX_WIDTH-1:0] r_index;

  logic [INDEX_WIDTH-1:0] w_addr_index, w_rd_index, w_wr_index, w_init_index;
  pmem_bus                w_wr_data;
  logic                   w_load_req, w_load_rdata, w_mem_write, w_init_active;
  logic                   w_unused_addr;

  pmem_responder_control #(
    .LATENCY     (LATENCY),
    .INDEX_WIDTH (INDEX_WIDTH)
  ) u_control (
    .clk           (clk),
    .reset         (reset),
    .i_read        (pmem_read),
    .i_write       (pmem_write),
    .o_load_req    (w_load_req),
    .o_load_rdata  (w_load_rdata),
    .o_mem_write   (w_mem_write),
    .o_pmem_resp   (pmem_resp),
    .o_init_active (w_init_active),
    .o_init_index  (w_init_index)
  );

  // Offset and aliased upper address bits are intentionally dropped.
  assign w_addr_index  = pmem_address[IDX_HI:IDX_LO];
  assign w_unused_addr = ^pmem_address;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_index <= '0;
      r_wdata <= '0;
    end else if (w_load_req) begin
      r_index <= w_addr_index;
      r_wdata <= pmem_wdata;
    end
  end

  // With LATENCY=1 the read fetch happens on the accepting edge itself.
  assign w_rd_index = w_load_req ? w_addr_index : r_index;
  assign w_wr_index = w_init_active ? w_init_index : r_index;
  assign w_wr_data  = w_init_active ? '0 : r_wdata;

  always_ff @(posedge clk) begin
    if (w_mem_write) r_mem[w_wr_index] <= w_wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) r_rdata <= '0;
    else if (w_load_rdata) r_rdata <= r_mem[w_rd_index];
  end

  assign pmem_rdata = r_rdata;

endmodule

// File: tb/tb_pmem_responder.sv
// Scoreboard bench for pmem_responder: stimulus pushes expected responses,
// a negedge monitor pops and checks resp cycle and rdata.
module tb_pmem_responder;

  localparam int LAT = 4;
`ifdef PMEM_ZERO_INIT_EN
  localparam int IW       = 4;
  localparam int INIT_CYC = 16;
`else
  localparam int IW       = 8;
  localparam int INIT_CYC = 0;
`endif

  localparam logic [127:0] L1   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] LA   = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] L55  = {8{16'h5555}};
  localparam logic [127:0] LAA  = {8{16'hAAAA}};

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  pmem_responder #(
    .LATENCY     (LAT),
    .INDEX_WIDTH (IW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_wdata   (pmem_wdata),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string        name;
    logic [127:0] rdata;
    int           cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: every resp cycle must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (pmem_resp === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_resp", 128'(cyc), 128'(-1));
      end else begin
        mon_e = q.pop_front();
        $display("resp %s cyc=%0d rdata=%h", mon_e.name, cyc, pmem_rdata);
        check({mon_e.name, "_cyc"}, 128'(cyc), 128'(mon_e.cyc));
        check({mon_e.name, "_rdata"}, pmem_rdata, mon_e.rdata);
      end
    end
  end

  task automatic push_exp(input string name, input logic [127:0] rd, input int c);
    exp_t e;
    e.name  = name;
    e.rdata = rd;
    e.cyc   = c;
    q.push_back(e);
  endtask

  // Waits for resp; scrambles request inputs after acceptance to prove they are ignored.
  task automatic wait_resp(input string name, input int budget);
    bit seen = 0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      if (k == 0) begin
        pmem_wdata   = ~pmem_wdata;
        pmem_address = pmem_address ^ 16'h0FF0;
      end
      if (pmem_resp === 1'b1) seen = 1;
    end
    if (!seen) check({name, "_timeout"}, 128'(pmem_resp), 128'(1));
  endtask

  task automatic finish_op(input bit hold);
    if (!hold) begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
    end
    @(negedge clk);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    @(negedge clk);
  endtask

  // Call at a negedge while the DUT will be IDLE at the next edge.
  task automatic do_op(input string name, input logic [15:0] addr, input logic rd, input logic wr,
                       input logic [127:0] wd, input logic [127:0] exp_rd, input bit hold);
    pmem_address = addr;
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_wdata   = wd;
    push_exp(name, exp_rd, cyc + LAT);
    wait_resp(name, 300);
    finish_op(hold);
  endtask

  initial begin
    reset        = 1'b1;
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    repeat (3) @(negedge clk);
    check("reset_resp", 128'(pmem_resp), 128'(0));
    check("reset_rdata", pmem_rdata, 128'h0);

`ifdef PMEM_ZERO_INIT_EN
    pmem_address = 16'h0000;
    pmem_read    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push_exp("init_read", 128'h0, cyc + INIT_CYC + LAT);
    wait_resp("init_read", 300);
    finish_op(1'b0);
`else
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_rdata", pmem_rdata, 128'h0);
`endif

    do_op("wr_1230",     16'h1230, 1'b0, 1'b1, L1,   128'h0, 1'b0);
    do_op("rd_123F",     16'h123F, 1'b1, 1'b0, '0,   L1,     1'b0);
    do_op("rd_held",     16'h123F, 1'b1, 1'b0, '0,   L1,     1'b1);
    repeat (6) @(negedge clk);
    do_op("wr_0010",     16'h0010, 1'b0, 1'b1, LA,   L1,     1'b0);
    do_op("rd_alias",    16'h1010, 1'b1, 1'b0, '0,   LA,     1'b0);
    do_op("rdwr_0040",   16'h0040, 1'b1, 1'b1, ONES, LA,     1'b0);
    do_op("rd_0040",     16'h0040, 1'b1, 1'b0, '0,   ONES,   1'b0);
    do_op("wr_0080",     16'h0080, 1'b0, 1'b1, L55,  ONES,   1'b0);

    // Abort a write while BUSY: no resp, no commit, rdata cleared.
    pmem_address = 16'h0080;
    pmem_write   = 1'b1;
    pmem_wdata   = LAA;
    $display("abort write 0080 at cyc=%0d", cyc);
    repeat (2) @(negedge clk);
    reset      = 1'b1;
    pmem_write = 1'b0;
    @(negedge clk);
    check("mid_reset_resp", 128'(pmem_resp), 128'(0));
    check("mid_reset_rdata", pmem_rdata, 128'h0);
    reset = 1'b0;
    repeat (INIT_CYC + 2) @(negedge clk);
    check("after_reset_rdata", pmem_rdata, 128'h0);

    do_op("rd_0080",     16'h0080, 1'b1, 1'b0, '0, (INIT_CYC != 0) ? 128'h0 : L55, 1'b0);
    do_op("b2b_rd_1230", 16'h1230, 1'b1, 1'b0, '0, L1, 1'b0);
    do_op("b2b_rd_0010", 16'h0010, 1'b1, 1'b0, '0, LA, 1'b0);

    repeat (8) @(negedge clk);
    check("queue_drained", 128'(q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
